// File: rtl/ins_sequencer.sv
// -----------------------------------------------------------------------------
// ins_sequencer
//
// Program sequencer for the Saber instruction ROM. It walks the ROM from
// START_ADDR, waits out the ROM read latency, decodes each 37-bit word
// {we1, we0, op3[9:0], op2[9:0], op1[9:0], ins[4:0]} and issues it to the
// datapath as a one-cycle ins_valid strobe. It then waits for ins_done before
// fetching the next word.
//
// ROM timing: rom_address changes on the clock edge that enters FETCH. The word
// is captured on the ROM_LAT-th rising edge after that. ROM_LAT=1 therefore
// suits a combinational ROM. ROM_LAT=2 suits a ROM with one output register,
// such as a block RAM fed directly from rom_address.
//
// Instruction classes:
//   ins = 0  (NOP)  : issued, then the next word is fetched without waiting.
//   ins = 31 (HALT) : issued with a done pulse, then the block returns to idle.
//   any other       : issued, then the block waits for ins_done.
// Stepping past the last ROM address without a HALT sets error and returns
// to idle. The pc does not wrap to 0.
//
// Optional feature (macro SEQ_TIMEOUT_EN):
//   When defined, a watchdog counts the cycles spent waiting for ins_done.
//   After TIMEOUT_CYCLES such cycles with no ins_done, it sets error and
//   returns to idle. When undefined, WAIT blocks until ins_done arrives.
//
// Parameters:
//   ADDR_W          ROM address width; the program space is 0..2^ADDR_W-1
//   START_ADDR      first address fetched after start
//   ROM_LAT         cycles from a rom_address change to a valid rom_data (1..3)
//   TIMEOUT_CYCLES  watchdog limit in WAIT (used only with SEQ_TIMEOUT_EN)
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous reset, active low
//   start        in   1       request to run the program from START_ADDR
//   rom_address  out  ADDR_W  instruction ROM address
//   rom_data     in   37      ROM word, valid ROM_LAT cycles after the address
//   ins_valid    out  1       one-cycle issue strobe to the datapath
//   ins_code     out  5       decoded ins field
//   op1/op2/op3  out  10      decoded operand fields
//   we0/we1      out  1       decoded write enables
//   ins_done     in   1       datapath completion; honoured only in WAIT
//   busy         out  1       high from start acceptance until the return to idle
//   done         out  1       one-cycle pulse issued together with a HALT
//   error        out  1       sticky overrun/timeout flag; cleared by the next start
// -----------------------------------------------------------------------------
module ins_sequencer #(
  parameter int ADDR_W         = 6,
  parameter int START_ADDR     = 0,
  parameter int ROM_LAT        = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [36:0]       rom_data,
  output logic              ins_valid,
  output logic [4:0]        ins_code,
  output logic [9:0]        op1,
  output logic [9:0]        op2,
  output logic [9:0]        op3,
  output logic              we0,
  output logic              we1,
  input  logic              ins_done,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [4:0]        INS_NOP  = 5'd0;
  localparam logic [4:0]        INS_HALT = 5'd31;
  localparam logic [ADDR_W-1:0] PC_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] PC_LAST  = {ADDR_W{1'b1}};
  // Two bits cover the supported latency range of 1..3.
  localparam int                LAT_W    = 2;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(ROM_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              error_q, error_d;

  // Decoded fields. They are loaded only on the last FETCH cycle, so they stay
  // stable from one ISSUE to the next.
  logic [4:0]        ins_q;
  logic [9:0]        op1_q, op2_q, op3_q;
  logic              we0_q, we1_q;

  logic              latch_en;
  logic              advance;
  logic              wd_expired;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // The counter is held at zero outside WAIT. That clears it on every entry
  // to WAIT.
  always_comb begin
    wd_d = '0;
    if (state_q == S_WAIT) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // The watchdog fires during the TIMEOUT_CYCLES-th consecutive WAIT cycle.
  assign wd_expired = (state_q == S_WAIT) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign wd_expired         = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    lat_d    = lat_q;
    error_d  = error_q;
    latch_en = 1'b0;
    advance  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start is seen only here. A start raised while a program runs,
        // including in the HALT issue cycle, has no effect.
        if (start) begin
          pc_d    = PC_START;
          lat_d   = '0;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (lat_q == LAT_LAST) begin
          latch_en = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_ISSUE: begin
        if (ins_q == INS_NOP) begin
          advance = 1'b1;
        end else if (ins_q == INS_HALT) begin
          // The pc stays on the HALT word.
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (ins_done) begin
          advance = 1'b1;
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Move to the next word. Running off the end of the ROM is an error, not a
    // wrap to address 0.
    if (advance) begin
      if (pc_q == PC_LAST) begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        pc_d    = pc_q + ADDR_W'(1);
        lat_d   = '0;
        state_d = S_FETCH;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_START;
      lat_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lat_q   <= lat_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      op3_q <= '0;
      we0_q <= 1'b0;
      we1_q <= 1'b0;
    end else if (latch_en) begin
      ins_q <= rom_data[4:0];
      op1_q <= rom_data[14:5];
      op2_q <= rom_data[24:15];
      op3_q <= rom_data[34:25];
      we0_q <= rom_data[35];
      we1_q <= rom_data[36];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rom_address = pc_q;
  assign ins_valid   = (state_q == S_ISSUE);
  assign ins_code    = ins_q;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign op3         = op3_q;
  assign we0         = we0_q;
  assign we1         = we1_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_ISSUE) && (ins_q == INS_HALT);
  assign error       = error_q;

endmodule

// File: tb/tb_ins_sequencer.sv
// Testbench for ins_sequencer. It models a one-register ROM (ROM_LAT=2) and a
// datapath responder. Expected issue times, issue addresses and flag values
// come from walking the program and adding up per-instruction cycle costs.
module tb_ins_sequencer;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  rom_address;
  logic [36:0] rom_data;
  logic        ins_valid;
  logic [4:0]  ins_code;
  logic [9:0]  op1, op2, op3;
  logic        we0, we1;
  logic        ins_done;
  logic        busy, done, error;

  logic [36:0] rom_mem [0:63];
  logic [36:0] rom_q;

  int          n_checks;
  int          n_errors;
  logic [36:0] last_word;
  logic        last_err;

  typedef struct {
    logic [36:0] word;
    logic [4:0]  ins;
    logic [9:0]  o1;
    logic [9:0]  o2;
    logic [9:0]  o3;
    logic        w0;
    logic        w1;
  } vec_t;

  vec_t vecs [4];

  ins_sequencer #(
    .ADDR_W(6),
    .START_ADDR(0),
    .ROM_LAT(LAT),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rom_address(rom_address),
    .rom_data(rom_data),
    .ins_valid(ins_valid),
    .ins_code(ins_code),
    .op1(op1),
    .op2(op2),
    .op3(op3),
    .we0(we0),
    .we1(we1),
    .ins_done(ins_done),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with one output register, matching ROM_LAT=2.
  always @(posedge clk) rom_q <= rom_mem[rom_address];
  assign rom_data = rom_q;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  function automatic logic [36:0] out_word();
    return {we1, we0, op3, op2, op1, ins_code};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rom_address"}, rom_address, 0);
    chk({tag, " ins_valid"}, ins_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " error"}, error, 0);
    chk({tag, " fields"}, out_word(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    start    = 1'b0;
    ins_done = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    last_word = '0;
    last_err  = 1'b0;
  endtask

  task automatic load_test1(input logic [36:0] mid);
    for (int a = 0; a < 64; a++) rom_mem[a] = '0;
    rom_mem[1] = mid;
    rom_mem[2] = 37'h1F;
  endtask

  task automatic load_random(input int len, input bit with_halt);
    logic [63:0] rw;
    logic [36:0] w;
    for (int a = 0; a < 64; a++) begin
      rw = {$urandom(), $urandom()};
      w  = rw[36:0];
      w[4:0] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 30));
      rom_mem[a] = w;
    end
    if (with_halt) rom_mem[len][4:0] = 5'd31;
  endtask

  // Runs one program from start to idle and checks every cycle. Cycle 0 is
  // the idle cycle in which start is driven.
  task automatic run_prog(input string tag, input bit stray, input bit noise,
                          input int fix_d, input int long_idx, input int long_d,
                          input int vec_idx, input vec_t v);
    int addrs[$];
    int dly[$];
    int iss[$];
    int n, t, d, k, end_c;
    bit halted, ev, win;
    logic [36:0] w, cur;

    halted = 0;
    for (int a = 0; a < 64; a++) begin
      addrs.push_back(a);
      w = rom_mem[a];
      if (w[4:0] == 5'd31) begin
        halted = 1;
        break;
      end
    end
    n = addrs.size();
    t = LAT + 1;
    for (int i = 0; i < n; i++) begin
      iss.push_back(t);
      w = rom_mem[addrs[i]];
      if (w[4:0] == 5'd0 || w[4:0] == 5'd31) d = 0;
      else if (i == long_idx) d = long_d;
      else if (fix_d > 0) d = fix_d;
      else d = int'($urandom_range(1, 4));
      dly.push_back(d);
      t = t + LAT + 1 + d;
    end
    end_c = iss[n-1] + dly[n-1] + 1;

    k = 0;
    for (int c = 0; c <= end_c + 2; c++) begin
      @(negedge clk);
      ev = (k < n) && (c == iss[k]);
      if (ev) k++;
      chk($sformatf("%s c%0d ins_valid", tag, c), ins_valid, ev);
      chk($sformatf("%s c%0d busy", tag, c), busy, (c >= 1 && c < end_c));
      chk($sformatf("%s c%0d done", tag, c), done, (halted && ev && k == n));
      chk($sformatf("%s c%0d error", tag, c), error,
          (c == 0) ? last_err : (!halted && c >= end_c));
      cur = (k > 0) ? rom_mem[addrs[k-1]] : last_word;
      chk($sformatf("%s c%0d fields", tag, c), out_word(), cur);
      if (ev) begin
        chk($sformatf("%s c%0d issue_addr", tag, c), rom_address, addrs[k-1]);
        if (k - 1 == vec_idx) begin
          chk({tag, " vec ins_code"}, ins_code, v.ins);
          chk({tag, " vec op1"}, op1, v.o1);
          chk({tag, " vec op2"}, op2, v.o2);
          chk({tag, " vec op3"}, op3, v.o3);
          chk({tag, " vec we0"}, we0, v.w0);
          chk({tag, " vec we1"}, we1, v.w1);
        end
      end
      // Inputs for this cycle; the DUT samples them on the next rising edge.
      start = (c == 0) ||
              (noise && c >= 1 && c < end_c &&
               (c == 5 || (halted && c == iss[n-1]) || $urandom_range(0, 3) == 0));
      win = (k > 0) && (dly[k-1] > 0) && (c > iss[k-1]) && (c <= iss[k-1] + dly[k-1]);
      if (win) ins_done = (c == iss[k-1] + dly[k-1]);
      else     ins_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == end_c + 2) begin
        start    = 1'b0;
        ins_done = 1'b0;
      end
    end
    $display("run %s: %0d issues, %s at cycle %0d", tag, n, halted ? "halt" : "overrun", end_c);
    last_word = rom_mem[addrs[n-1]];
    last_err  = !halted;
  endtask

  initial begin
    int nv;
    int bad;
    n_checks  = 0;
    n_errors  = 0;
    last_word = '0;
    last_err  = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    ins_done  = 1'b0;
    for (int a = 0; a < 64; a++) rom_mem[a] = '0;

    // Raw ROM words and their decoded fields worked out by hand.
    vecs[0] = '{37'h08F8000F81, 5'd1,  10'd124,  10'd0,    10'd124,  1'b1, 1'b0};
    vecs[1] = '{37'h17FEAAD545, 5'd5,  10'h2AA,  10'h155,  10'h3FF,  1'b0, 1'b1};
    vecs[2] = '{37'h1C0001003E, 5'd30, 10'd1,    10'd2,    10'h200,  1'b1, 1'b1};
    vecs[3] = '{37'h0000000002, 5'd2,  10'd0,    10'd0,    10'd0,    1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    // Decode table. Entry 0 is the NOP / ins=1 / HALT program.
    for (int i = 0; i < 4; i++) begin
      load_test1(vecs[i].word);
      run_prog($sformatf("table%0d", i), 0, 0, 1, -1, 0, 1, vecs[i]);
    end

    // ins_done held low for 20 WAIT cycles, with stray pulses elsewhere.
    load_test1(vecs[0].word);
    run_prog("long_wait", 1, 0, 1, 1, 21, -1, vecs[0]);

    // start pulses while busy, including in the HALT issue cycle.
    run_prog("start_noise", 0, 1, 1, -1, 0, -1, vecs[0]);

    // All-NOP ROM runs off the end; the next start clears error.
    for (int a = 0; a < 64; a++) rom_mem[a] = '0;
    run_prog("overrun_nop", 1, 1, 0, -1, 0, -1, vecs[0]);
    load_test1(vecs[1].word);
    run_prog("after_overrun", 0, 0, 1, -1, 0, -1, vecs[0]);

    // Random programs with random datapath delays.
    for (int r = 0; r < 6; r++) begin
      load_random(int'($urandom_range(2, 10)), 1);
      run_prog($sformatf("rand%0d", r), 1, 1, 0, -1, 0, -1, vecs[0]);
    end
    load_random(0, 0);
    run_prog("overrun_rand", 1, 1, 0, -1, 0, -1, vecs[0]);
    load_test1(vecs[2].word);
    run_prog("after_rand_overrun", 1, 0, 0, -1, 0, -1, vecs[0]);

    // Asynchronous reset while waiting on the instruction at pc=3.
    for (int a = 0; a < 64; a++) rom_mem[a] = '0;
    rom_mem[3] = vecs[1].word;
    rom_mem[4] = 37'h1F;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    for (int c = 0; c < 100 && nv < 4; c++) begin
      @(negedge clk);
      if (ins_valid) nv++;
    end
    chk("t5 issues_before_wait", nv, 4);
    chk("t5 issue_addr", rom_address, 3);
    @(negedge clk);
    chk("t5 busy_in_wait", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5 async");
    @(negedge clk);
    chk_reset_outputs("t5 held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("t5 idle");
    last_word = '0;
    last_err  = 1'b0;

    // Datapath never answers.
    for (int a = 0; a < 64; a++) rom_mem[a] = '0;
    rom_mem[0] = vecs[3].word;
    rom_mem[1] = 37'h1F;
    @(negedge clk);
    start = 1'b1;
    bad = 0;
`ifdef SEQ_TIMEOUT_EN
    for (int c = 1; c <= LAT + 1 + 17; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == LAT + 1) chk("t6 issue", ins_valid, 1);
      if (c > LAT + 1 && c < LAT + 1 + 17 && (error || !busy)) bad++;
      if (c == LAT + 1 + 17) begin
        chk("t6 timeout_error", error, 1);
        chk("t6 timeout_busy", busy, 0);
        chk("t6 timeout_done", done, 0);
      end
    end
    chk("t6 wait_window", bad, 0);
`else
    for (int c = 1; c <= 1003; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == LAT + 1) chk("t6 issue", ins_valid, 1);
      if (c > LAT + 1 && (error || !busy || ins_valid)) bad++;
    end
    chk("t6 still_busy", busy, 1);
    chk("t6 no_error", error, 0);
    chk("t6 wait_window", bad, 0);
`endif
    do_reset();
    @(negedge clk);
    chk_reset_outputs("t6 recovered");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
